lockpick_session_arbiter: RTL and testbench

//  Shares one lockpick_game core among N_PLAYERS requesters. Round-robin grants a whole

---
 rtl/lockpick_session_arbiter.sv | 172 +++++++++++++++++
 tb/tb_lockpick_session_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockpick_session_arbiter.sv
// lockpick_session_arbiter
//   Shares a single lockpick_game core among N_PLAYERS requesters. A round-robin
//   pick hands one player a whole session of up to MAX_ATTEMPTS attempts. The
//   arbiter pulses core_start once per session, passes the owner's key bytes to
//   the core, forwards the core's result bytes back, and samples core_status
//   after the last result byte of each attempt. It reports every attempt on
//   res_* and keeps a saturating win counter for each player.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset (shared with the core)
//   req[N]                      level request per player
//   grant[N]                    one-hot session owner, all zero when idle
//   in_valid/in_data/in_ready   key byte stream from the owner
//   out_valid/out_data          core result bytes forwarded to the owner
//   res_valid/res_player/res_status  one-cycle end-of-attempt report
//   wins[N*8]                   per-player win count, saturating at 255
//   core_*                      connection to the lockpick_game core
module lockpick_session_arbiter #(
    parameter int unsigned N_PLAYERS    = 4,
    parameter int unsigned IN_BYTES     = 32,
    parameter int unsigned OUT_BYTES    = 16,
    parameter int unsigned MAX_ATTEMPTS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PLAYERS-1:0]   req,
    output logic [N_PLAYERS-1:0]   grant,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   res_valid,
    output logic [2:0]             res_player,
    output logic [1:0]             res_status,
    output logic [N_PLAYERS*8-1:0] wins,
    output logic                   core_start,
    output logic                   core_input_enable,
    output logic [7:0]             core_input_data,
    input  logic                   core_output_valid,
    input  logic [7:0]             core_output_data,
    input  logic [1:0]             core_status
);

    typedef enum logic [1:0] {IDLE, START, LOAD, DRAIN} state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic [2:0]          owner;
    logic [5:0]          byte_cnt;
    logic [1:0]          attempt;
    logic [7:0]          win_cnt [N_PLAYERS];

    logic                found;
    logic [2:0]          pick;
    logic [N_PLAYERS-1:0] pick_onehot;
    int unsigned         idx;
    logic [2:0]          rr_next;
    logic [1:0]          status_eff;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        pick_onehot = '0;
        for (int unsigned k = 0; k < N_PLAYERS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_PLAYERS) idx = idx - N_PLAYERS;
            for (int unsigned g = 0; g < N_PLAYERS; g++) begin
                if (!found && g == idx && req[g]) begin
                    found = 1'b1;
                    pick  = 3'(g);
                end
            end
        end
        for (int unsigned g = 0; g < N_PLAYERS; g++) begin
            pick_onehot[g] = (pick == 3'(g));
        end
    end

    assign rr_next    = (owner == 3'(N_PLAYERS - 1)) ? 3'd0 : owner + 3'd1;
    // A status of 00 at the sample point counts as an error.
    assign status_eff = (core_status == 2'b00) ? 2'b01 : core_status;

    assign core_input_enable = in_valid & in_ready;
    assign core_input_data   = in_data;
    assign out_valid         = core_output_valid & (state == DRAIN);
    assign out_data          = core_output_data;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_wins
        assign wins[g*8 +: 8] = win_cnt[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            in_ready   <= 1'b0;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_player <= '0;
            res_status <= '0;
            byte_cnt   <= '0;
            attempt    <= '0;
            for (int unsigned g = 0; g < N_PLAYERS; g++) win_cnt[g] <= '0;
        end else begin
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick_onehot;
                        owner      <= pick;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    attempt  <= 2'd1;
                    byte_cnt <= '0;
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (core_input_enable) begin
                        if (byte_cnt == 6'(IN_BYTES - 1)) begin
                            byte_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (core_output_valid) begin
                        if (byte_cnt == 6'(OUT_BYTES - 1)) begin
                            byte_cnt   <= '0;
                            res_valid  <= 1'b1;
                            res_status <= status_eff;
                            res_player <= owner;
                            if (status_eff == 2'b10) begin
                                for (int unsigned g = 0; g < N_PLAYERS; g++) begin
                                    if (owner == 3'(g) && win_cnt[g] != 8'hFF)
                                        win_cnt[g] <= win_cnt[g] + 8'd1;
                                end
                            end
                            // Only a plain error with attempts left retries; the
                            // core keeps its session, so no new core_start.
                            if (status_eff == 2'b01 && attempt != 2'(MAX_ATTEMPTS)) begin
                                attempt  <= attempt + 2'd1;
                                in_ready <= 1'b1;
                                state    <= LOAD;
                            end else begin
                                grant  <= '0;
                                rr_ptr <= rr_next;
                                state  <= IDLE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_session_arbiter.sv
module tb_lockpick_session_arbiter;

    localparam int N    = 4;
    localparam int IN_B = 32;
    localparam int OUT_B = 16;
    localparam int MAXA = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           res_valid;
    logic [2:0]     res_player;
    logic [1:0]     res_status;
    logic [N*8-1:0] wins;
    logic           core_start;
    logic           core_input_enable;
    logic [7:0]     core_input_data;
    logic           core_output_valid;
    logic [7:0]     core_output_data;
    logic [1:0]     core_status;

    int total = 0;
    int bad   = 0;

    lockpick_session_arbiter #(
        .N_PLAYERS(N), .IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .MAX_ATTEMPTS(MAXA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .res_valid(res_valid), .res_player(res_player), .res_status(res_status),
        .wins(wins), .core_start(core_start), .core_input_enable(core_input_enable),
        .core_input_data(core_input_data), .core_output_valid(core_output_valid),
        .core_output_data(core_output_data), .core_status(core_status)
    );

    always #5 clk = ~clk;

    // Observation of DUT activity, sampled on the falling edge.
    int         n_start, n_en, n_outv, fwd_bad;
    logic [7:0] en_q[$];
    logic [7:0] sent_q[$];
    logic [4:0] res_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) n_start++;
            if (core_input_enable) begin
                n_en++;
                en_q.push_back(core_input_data);
            end
            if (out_valid) begin
                n_outv++;
                if (out_data !== core_output_data) fwd_bad++;
            end
            if (res_valid) res_q.push_back({res_player, res_status});
        end
    end

    // Reference model: round-robin pointer and win tallies.
    int rr_m;
    int wins_m[N];

    task automatic model_session(input logic [N-1:0] r, input logic [1:0] st[3],
                                 output int p, output int na, output logic [4:0] ex[3]);
        p = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (rr_m + k) % N;
            if (p < 0 && r[c]) p = c;
        end
        na = 0;
        for (int a = 0; a < MAXA; a++) begin
            logic [1:0] s;
            s = (st[a] == 2'b00) ? 2'b01 : st[a];
            ex[a] = {3'(p), s};
            na++;
            if (s == 2'b10) begin
                if (wins_m[p] < 255) wins_m[p]++;
                break;
            end
            if (s == 2'b11) break;
        end
        rr_m = (p + 1) % N;
    endtask

    function automatic logic [N*8-1:0] wins_exp();
        logic [N*8-1:0] w;
        for (int k = 0; k < N; k++) w[k*8 +: 8] = 8'(wins_m[k]);
        return w;
    endfunction

    task automatic clear_mon();
        n_start = 0; n_en = 0; n_outv = 0; fwd_bad = 0;
        en_q.delete(); sent_q.delete(); res_q.delete();
    endtask

    // Drives one session: request, na attempts of key bytes and result bytes.
    // stall is the percentage of idle cycles; abort_at >= 0 asserts reset after
    // that many result bytes of the first attempt.
    task automatic run_session(input logic [N-1:0] r, input bit drop, input logic [1:0] st[3],
                               input int na, input int stall, input int abort_at,
                               output logic [N-1:0] g);
        int cyc;
        int n;
        @(posedge clk); #1;
        req = r;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (grant == '0 && cyc < 20);
        g = grant;
        if (grant == '0) begin
            total++; bad++;
            $display("FAIL grant_timeout got=%b want=nonzero", grant);
            return;
        end
        if (drop) req = '0;
        for (int a = 0; a < na; a++) begin
            n = 0;
            cyc = 0;
            while (n < IN_B && cyc < 4000) begin
                @(posedge clk); #1;
                in_valid = ($urandom_range(99) >= stall);
                in_data  = 8'($urandom);
                @(negedge clk);
                cyc++;
                if (core_input_enable) begin
                    n++;
                    sent_q.push_back(in_data);
                end
            end
            if (n < IN_B) begin
                total++; bad++;
                $display("FAIL load_timeout got=%0d want=%0d", n, IN_B);
                in_valid = 1'b0;
                return;
            end
            n = 0;
            while (n < OUT_B) begin
                @(posedge clk); #1;
                in_valid    = 1'b0;
                core_status = st[a];
                if (n == abort_at) begin
                    core_output_valid = 1'b0;
                    rst_n = 1'b0;
                    return;
                end
                core_output_valid = (stall == 0) ? 1'b1 : 1'($urandom_range(1));
                core_output_data  = 8'($urandom);
                @(negedge clk);
                if (core_output_valid) n++;
            end
            @(posedge clk); #1;
            core_output_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({grant, in_ready, core_start, res_valid, res_player, res_status, out_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {grant, in_ready, core_start, res_valid, res_player, res_status, out_valid});
        end
        total++;
        if (wins !== '0) begin bad++; $display("FAIL reset_wins got=%h want=0", wins); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (grant !== '0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req got=%b/%b want=0/0", grant, in_ready);
        end
        rr_m = 0;
        for (int k = 0; k < N; k++) wins_m[k] = 0;
    endtask

    task automatic test_single_win();
        logic [1:0] st[3] = '{2'b10, 2'b00, 2'b00};
        logic [4:0] ex[3];
        logic [N-1:0] g;
        int p, na;
        clear_mon();
        model_session(4'b0001, st, p, na, ex);
        run_session(4'b0001, 1'b1, st, na, 0, -1, g);
        total++;
        if (g !== N'(1 << p)) begin bad++; $display("FAIL win_grant got=%b want=%b", g, N'(1 << p)); end
        total++;
        if (n_start !== 1) begin bad++; $display("FAIL win_start got=%0d want=1", n_start); end
        total++;
        if (res_q.size() !== 1 || res_q[0] !== ex[0]) begin
            bad++;
            $display("FAIL win_res got=%0d/%b want=1/%b", res_q.size(), res_q.size() ? res_q[0] : 5'b0, ex[0]);
        end
        total++;
        if (wins !== wins_exp()) begin bad++; $display("FAIL win_count got=%h want=%h", wins, wins_exp()); end
        total++;
        if (grant !== '0) begin bad++; $display("FAIL win_grant_clear got=%b want=0", grant); end
        total++;
        if (n_outv !== OUT_B || fwd_bad !== 0) begin
            bad++;
            $display("FAIL win_forward got=%0d/%0d want=%0d/0", n_outv, fwd_bad, OUT_B);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] st[3] = '{2'b10, 2'b00, 2'b00};
        logic [4:0] ex[3];
        logic [N-1:0] reqs[4] = '{4'b0110, 4'b0110, 4'b0011, 4'b0011};
        bit drops[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [N-1:0] g;
        int p, na;
        for (int s = 0; s < 4; s++) begin
            clear_mon();
            model_session(reqs[s], st, p, na, ex);
            run_session(reqs[s], drops[s], st, na, 10, -1, g);
            total++;
            if (g !== N'(1 << p)) begin
                bad++;
                $display("FAIL rr_grant[%0d] got=%b want=%b", s, g, N'(1 << p));
            end
            total++;
            if (res_q.size() !== 1 || res_q[0] !== ex[0]) begin
                bad++;
                $display("FAIL rr_res[%0d] got=%0d want=%b", s, res_q.size(), ex[0]);
            end
        end
        total++;
        if (wins !== wins_exp()) begin bad++; $display("FAIL rr_wins got=%h want=%h", wins, wins_exp()); end
    endtask

    task automatic test_retry(input logic [N-1:0] r, input logic [1:0] st[3]);
        logic [4:0] ex[3];
        logic [N-1:0] g;
        int p, na;
        clear_mon();
        model_session(r, st, p, na, ex);
        run_session(r, 1'b1, st, na, 20, -1, g);
        total++;
        if (n_start !== 1) begin bad++; $display("FAIL retry_start got=%0d want=1", n_start); end
        total++;
        if (n_en !== IN_B * na) begin bad++; $display("FAIL retry_bytes got=%0d want=%0d", n_en, IN_B * na); end
        total++;
        if (res_q.size() !== na) begin
            bad++;
            $display("FAIL retry_res_count got=%0d want=%0d", res_q.size(), na);
        end else begin
            for (int i = 0; i < na; i++) begin
                total++;
                if (res_q[i] !== ex[i]) begin
                    bad++;
                    $display("FAIL retry_res[%0d] got=%b want=%b", i, res_q[i], ex[i]);
                end
            end
        end
        total++;
        if (grant !== '0 || wins !== wins_exp()) begin
            bad++;
            $display("FAIL retry_end got=%b/%h want=0/%h", grant, wins, wins_exp());
        end
    endtask

    task automatic test_stall();
        logic [1:0] st[3] = '{2'b10, 2'b00, 2'b00};
        logic [4:0] ex[3];
        logic [N-1:0] g;
        int p, na, mis;
        clear_mon();
        model_session(4'b0100, st, p, na, ex);
        run_session(4'b0100, 1'b1, st, na, 50, -1, g);
        total++;
        if (n_en !== IN_B) begin bad++; $display("FAIL stall_enables got=%0d want=%0d", n_en, IN_B); end
        mis = 0;
        for (int i = 0; i < IN_B && i < en_q.size() && i < sent_q.size(); i++)
            if (en_q[i] !== sent_q[i]) mis++;
        total++;
        if (mis !== 0 || en_q.size() !== sent_q.size()) begin
            bad++;
            $display("FAIL stall_data_order got=%0d want=0", mis);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [1:0] st[3] = '{2'b10, 2'b00, 2'b00};
        logic [4:0] ex[3];
        logic [N-1:0] g;
        int p, na;
        clear_mon();
        model_session(4'b0010, st, p, na, ex);
        run_session(4'b0010, 1'b1, st, na, 0, 7, g);
        #1;
        total++;
        if ({grant, in_ready, core_start, res_valid, res_player, res_status, out_valid} !== '0) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=0",
                     {grant, in_ready, core_start, res_valid, res_player, res_status, out_valid});
        end
        total++;
        if (wins !== '0) begin bad++; $display("FAIL abort_wins got=%h want=0", wins); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (res_q.size() !== 0) begin bad++; $display("FAIL abort_res got=%0d want=0", res_q.size()); end
        rr_m = 0;
        for (int k = 0; k < N; k++) wins_m[k] = 0;
        clear_mon();
        model_session(4'b1111, st, p, na, ex);
        run_session(4'b1111, 1'b1, st, na, 0, -1, g);
        total++;
        if (g !== N'(1 << p)) begin bad++; $display("FAIL abort_rr got=%b want=%b", g, N'(1 << p)); end
    endtask

    task automatic test_saturate();
        logic [1:0] st[3] = '{2'b10, 2'b00, 2'b00};
        logic [4:0] ex[3];
        logic [N-1:0] g;
        int p, na;
        for (int s = 0; s < 256; s++) begin
            clear_mon();
            model_session(4'b1000, st, p, na, ex);
            run_session(4'b1000, 1'b1, st, na, 0, -1, g);
            if (s == 254 || s == 255) begin
                total++;
                if (wins !== wins_exp()) begin
                    bad++;
                    $display("FAIL sat_wins[%0d] got=%h want=%h", s, wins, wins_exp());
                end
            end
        end
        total++;
        if (res_q.size() !== 1 || res_q[0] !== ex[0]) begin
            bad++;
            $display("FAIL sat_last_res got=%0d want=%b", res_q.size(), ex[0]);
        end
    endtask

    initial begin
        req = '0; in_valid = 1'b0; in_data = '0;
        core_output_valid = 1'b0; core_output_data = '0; core_status = '0;
        clear_mon();
        test_reset();
        test_single_win();
        test_round_robin();
        test_retry(4'b0001, '{2'b01, 2'b01, 2'b11});
        test_retry(4'b0100, '{2'b00, 2'b01, 2'b01});
        test_retry(4'b1000, '{2'b01, 2'b10, 2'b00});
        test_stall();
        test_reset_mid_drain();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
